pll_reset_conditioner: RTL and testbench

Consumes the lock indication of the board PLL and produces the design's conditioned, staged reset outputs in the PLL output clock domain. Holds all downstream logic in reset until lock has been stable for a programmable number of cycles, then releases reset stages in order with a fixed gap. Returns to reset immediately if lock is lost, and counts lock-loss events for debug. Sits directly after the PLL wrapper, ahead of every clocked block in the design.

---
 rtl/pll_reset_conditioner.sv | 121 ++++++++++++
 tb/tb_pll_reset_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_conditioner.sv
// Turns the asynchronous PLL lock flag into staged, flop-driven resets.
// Reset stages release low bit first once lock has been stable long enough.
module pll_reset_conditioner #(
  parameter int STABLE_CYCLES = 65536,
  parameter int STAGE_GAP     = 16,
  parameter int NUM_STAGES    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {HOLD, STAGE, RUN} stateT;

  stateT                 r_state, w_stateNext;
  logic                  r_lockMeta, r_lockS;
  logic [SW-1:0]         r_stableCnt, w_stableCntNext;
  logic [GW-1:0]         r_gapCnt, w_gapCntNext;
  logic [NUM_STAGES-1:0] r_rstOut, w_rstOutNext, w_released;
  logic                  r_ready, w_readyNext;
  logic [7:0]            r_lossCnt, w_lossCntNext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lockMeta <= 1'b0;
      r_lockS    <= 1'b0;
    end else begin
      r_lockMeta <= pll_lock;
      r_lockS    <= r_lockMeta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= HOLD;
      r_stableCnt <= '0;
      r_gapCnt    <= '0;
      r_rstOut    <= '1;
      r_ready     <= 1'b0;
      r_lossCnt   <= 8'd0;
    end else begin
      r_state     <= w_stateNext;
      r_stableCnt <= w_stableCntNext;
      r_gapCnt    <= w_gapCntNext;
      r_rstOut    <= w_rstOutNext;
      r_ready     <= w_readyNext;
      r_lossCnt   <= w_lossCntNext;
    end
  end

  // Reset bits are a thermometer: shifting left releases the lowest asserted bit.
  assign w_released = r_rstOut << 1;

  always_comb begin
    w_stateNext     = r_state;
    w_stableCntNext = r_stableCnt;
    w_gapCntNext    = r_gapCnt;
    w_rstOutNext    = r_rstOut;
    w_readyNext     = r_ready;
    w_lossCntNext   = r_lossCnt;
    if ((r_state != HOLD) && !r_lockS) begin
      w_stateNext     = HOLD;
      w_stableCntNext = '0;
      w_gapCntNext    = '0;
      w_rstOutNext    = '1;
      w_readyNext     = 1'b0;
      w_lossCntNext   = (r_lossCnt == 8'hFF) ? r_lossCnt : r_lossCnt + 8'd1;
    end else begin
      unique case (r_state)
        HOLD: begin
          if (!r_lockS) begin
            w_stableCntNext = '0;
          end else if (r_stableCnt == STABLE_LAST) begin
            w_stableCntNext = '0;
            w_gapCntNext    = '0;
            w_rstOutNext    = w_released;
            if (w_released == '0) begin
              w_stateNext = RUN;
              w_readyNext = 1'b1;
            end else begin
              w_stateNext = STAGE;
            end
          end else begin
            w_stableCntNext = r_stableCnt + SW'(1);
          end
        end
        STAGE: begin
          if (r_gapCnt == GAP_LAST) begin
            w_gapCntNext = '0;
            w_rstOutNext = w_released;
            if (w_released == '0) begin
              w_stateNext = RUN;
              w_readyNext = 1'b1;
            end
          end else begin
            w_gapCntNext = r_gapCnt + GW'(1);
          end
        end
        RUN: begin
          w_readyNext = 1'b1;
        end
        default: begin
          w_stateNext = HOLD;
        end
      endcase
    end
  end

  assign rst_out         = r_rstOut;
  assign ready           = r_ready;
  assign lock_loss_count = r_lossCnt;

endmodule

// File: tb/tb_pll_reset_conditioner.sv
// Directed bench: stimulus queues expected output changes with their edge numbers,
// a negedge monitor pops one entry each time the DUT outputs change.
module tb_pll_reset_conditioner;

  localparam int S = 8;
  localparam int G = 4;
  localparam int N = 3;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [7:0] cnt;
  } expT;

  logic         clock;
  logic         reset;
  logic         pll_lock;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [7:0]   lock_loss_count;

  expT  expQ[$];
  int   cyc;
  int   total;
  int   bad;
  int   expCnt;
  logic [11:0] lastOut;

  pll_reset_conditioner #(
    .STABLE_CYCLES(S),
    .STAGE_GAP(G),
    .NUM_STAGES(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pll_lock(pll_lock),
    .rst_out(rst_out),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic pushExp(input int c, input logic [2:0] r, input logic y, input int n);
    expT e;
    e.cyc = c;
    e.rst = r;
    e.rdy = y;
    e.cnt = n[7:0];
    expQ.push_back(e);
  endtask

  // Full release timeline measured from E0, the first edge that sees lock high.
  task automatic expectRelease(input int e0);
    pushExp(e0 + 1 + S,         3'b110, 1'b0, expCnt);
    pushExp(e0 + 1 + S + G,     3'b100, 1'b0, expCnt);
    pushExp(e0 + 1 + S + 2 * G, 3'b000, 1'b1, expCnt);
  endtask

  task automatic applyStimulus(input logic lockVal);
    @(negedge clock);
    pll_lock = lockVal;
  endtask

  task automatic checkOutput(input logic [2:0] r, input logic y, input logic [7:0] n);
    expT e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpectedChange cycle=%0d got rst=%b ready=%b cnt=%0d, required no change",
               cyc, r, y, n);
    end else begin
      e = expQ.pop_front();
      if (r !== e.rst || y !== e.rdy || n !== e.cnt || (e.cyc >= 0 && e.cyc != cyc)) begin
        bad++;
        $display("[TB] FAIL outputChange got cycle=%0d rst=%b ready=%b cnt=%0d, required cycle=%0d rst=%b ready=%b cnt=%0d",
                 cyc, r, y, n, e.cyc, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  initial begin
    lastOut = 'x;
    forever begin
      @(negedge clock);
      if ({rst_out, ready, lock_loss_count} !== lastOut) begin
        checkOutput(rst_out, ready, lock_loss_count);
        lastOut = {rst_out, ready, lock_loss_count};
      end
    end
  end

  initial begin
    int e0;
    int ek;
    total    = 0;
    bad      = 0;
    expCnt   = 0;
    reset    = 1'b1;
    pll_lock = 1'b0;
    pushExp(-1, 3'b111, 1'b0, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    $display("[TB] clean lock-up");
    applyStimulus(1'b1);
    e0 = cyc + 1;
    expectRelease(e0);
    repeat (20) @(negedge clock);

    $display("[TB] loss in RUN");
    applyStimulus(1'b0);
    ek = cyc + 1;
    expCnt++;
    pushExp(ek + 2, 3'b111, 1'b0, expCnt);
    repeat (4) @(negedge clock);

    $display("[TB] glitch in HOLD then re-lock");
    applyStimulus(1'b1);
    repeat (4) @(negedge clock);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    e0 = cyc + 1;
    expectRelease(e0);
    repeat (20) @(negedge clock);

    $display("[TB] loss mid-STAGE");
    applyStimulus(1'b0);
    ek = cyc + 1;
    expCnt++;
    pushExp(ek + 2, 3'b111, 1'b0, expCnt);
    repeat (4) @(negedge clock);
    applyStimulus(1'b1);
    e0 = cyc + 1;
    pushExp(e0 + 1 + S, 3'b110, 1'b0, expCnt);
    repeat (9) @(negedge clock);
    applyStimulus(1'b0);
    ek = cyc + 1;
    expCnt++;
    pushExp(ek + 2, 3'b111, 1'b0, expCnt);
    repeat (5) @(negedge clock);
    applyStimulus(1'b1);
    e0 = cyc + 1;
    expectRelease(e0);
    repeat (20) @(negedge clock);
    applyStimulus(1'b0);
    ek = cyc + 1;
    expCnt++;
    pushExp(ek + 2, 3'b111, 1'b0, expCnt);
    repeat (4) @(negedge clock);

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1);
      e0 = cyc + 1;
      pushExp(e0 + 1 + S, 3'b110, 1'b0, expCnt);
      repeat (9) @(negedge clock);
      applyStimulus(1'b0);
      ek = cyc + 1;
      if (expCnt < 255) expCnt++;
      pushExp(ek + 2, 3'b111, 1'b0, expCnt);
    end
    repeat (5) @(negedge clock);

    $display("[TB] async reset mid-STAGE");
    applyStimulus(1'b1);
    e0 = cyc + 1;
    pushExp(e0 + 1 + S, 3'b110, 1'b0, expCnt);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2;
    reset  = 1'b1;
    expCnt = 0;
    pushExp(cyc, 3'b111, 1'b0, 0);
    #2;
    reset = 1'b0;
    e0 = cyc + 1;
    expectRelease(e0);
    repeat (25) @(negedge clock);

    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL pendingChanges got %0d outstanding, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
